// File: rtl/knn_ctrl.sv
// Sequencer for the kNN distance core: streams data points per test point, keeps a sorted NBR_KNN list.
// Latency: 1 (LOAD) + nbr_datap (STREAM) + 1 (DRAIN) cycles per test point before the result is offered.
// Backpressure: RESULT holds res_valid/res_labels/res_idx until res_ready; no new reads are issued meanwhile.
module knn_ctrl #(
  parameter int DATA_W     = 32,
  parameter int LABEL_BITS = 8,
  parameter int NBR_KNN    = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            nbr_testp,
  input  logic [ADDR_W-1:0]            nbr_datap,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            test_addr,
  output logic                         test_rd,
  input  logic [DATA_W-1:0]            test_data,
  output logic [ADDR_W-1:0]            data_addr,
  output logic                         data_rd,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [LABEL_BITS-1:0]        label_in,
  output logic                         core_en,
  output logic [DATA_W-1:0]            core_a,
  output logic [DATA_W-1:0]            core_b,
  input  logic [DATA_W-1:0]            distance,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ADDR_W-1:0]            res_idx,
  output logic [NBR_KNN*LABEL_BITS-1:0] res_labels
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, RESULT} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     tp;
  logic [ADDR_W-1:0]     dp;
  logic [ADDR_W-1:0]     ti;
  logic                  load_d;

  logic [DATA_W-1:0]     list_dist [NBR_KNN];
  logic [LABEL_BITS-1:0] list_lbl  [NBR_KNN];
  logic [DATA_W-1:0]     nxt_dist  [NBR_KNN];
  logic [LABEL_BITS-1:0] nxt_lbl   [NBR_KNN];
  logic [NBR_KNN-1:0]    lt;

  // The data word is only presented to the core in compare cycles, so core_b idles at zero.
  assign core_b  = core_en ? data_in : '0;
  assign res_idx = ti;

  // The list is sorted ascending, so lt is monotonic: once set, it stays set for all later slots.
  // Slot i takes the new entry at the first set bit, the entry above it if the bit below was set,
  // else keeps its value. A strict compare leaves equal distances behind earlier points and never
  // lets an all-ones distance in.
  for (genvar i = 0; i < NBR_KNN; i++) begin : g_ins
    assign lt[i] = distance < list_dist[i];
    assign res_labels[i*LABEL_BITS +: LABEL_BITS] = list_lbl[i];
    if (i == 0) begin : g_head
      assign nxt_dist[i] = lt[i] ? distance : list_dist[i];
      assign nxt_lbl[i]  = lt[i] ? label_in : list_lbl[i];
    end else begin : g_tail
      assign nxt_dist[i] = lt[i-1] ? list_dist[i-1] : (lt[i] ? distance : list_dist[i]);
      assign nxt_lbl[i]  = lt[i-1] ? list_lbl[i-1]  : (lt[i] ? label_in : list_lbl[i]);
    end
  end

  // Neighbour list: cleared on LOAD, one insert per core_en cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBR_KNN; i++) begin
        list_dist[i] <= '1;
        list_lbl[i]  <= '0;
      end
    end else if (state == LOAD) begin
      for (int i = 0; i < NBR_KNN; i++) begin
        list_dist[i] <= '1;
        list_lbl[i]  <= '0;
      end
    end else if (core_en) begin
      for (int i = 0; i < NBR_KNN; i++) begin
        list_dist[i] <= nxt_dist[i];
        list_lbl[i]  <= nxt_lbl[i];
      end
    end
  end

  // Capture the test point the cycle after its read strobe; it holds until the next LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_d <= 1'b0;
      core_a <= '0;
    end else begin
      load_d <= (state == LOAD);
      if (load_d) begin
        core_a <= test_data;
      end
    end
  end

  // Run sequencer with registered strobes; core_en trails data_rd by the memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      test_rd   <= 1'b0;
      test_addr <= '0;
      data_rd   <= 1'b0;
      data_addr <= '0;
      core_en   <= 1'b0;
      res_valid <= 1'b0;
      tp        <= '0;
      dp        <= '0;
      ti        <= '0;
    end else begin
      done    <= 1'b0;
      core_en <= data_rd;
      case (state)
        IDLE: begin
          if (start) begin
            tp <= nbr_testp;
            dp <= nbr_datap;
            ti <= '0;
            if (nbr_testp == '0) begin
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              test_rd   <= 1'b1;
              test_addr <= '0;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          test_rd <= 1'b0;
          if (dp == '0) begin
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            data_rd   <= 1'b1;
            data_addr <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          // data_addr doubles as the stream counter; stopping at dp-1 avoids a wrap at full count.
          if (data_addr == dp - 1'b1) begin
            data_rd <= 1'b0;
            state   <= DRAIN;
          end else begin
            data_addr <= data_addr + 1'b1;
          end
        end
        DRAIN: begin
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ti        <= ti + 1'b1;
            if (ti == tp - 1'b1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              test_rd   <= 1'b1;
              test_addr <= ti + 1'b1;
              state     <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl with memory and distance-core models and a selection-based reference.
module tb_knn_ctrl;
  localparam int DW = 32;
  localparam int LB = 8;
  localparam int K  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] nbr_testp, nbr_datap;
  logic          busy, done;
  logic [AW-1:0] test_addr, data_addr;
  logic          test_rd, data_rd;
  logic [DW-1:0] test_data, data_in;
  logic [LB-1:0] label_in;
  logic          core_en;
  logic [DW-1:0] core_a, core_b, distance;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_idx;
  logic [K*LB-1:0] res_labels;

  logic [DW-1:0] test_mem  [256];
  logic [DW-1:0] data_mem  [256];
  logic [LB-1:0] label_mem [256];

  int checks = 0;
  int errors = 0;
  int n_data_rd = 0, n_test_rd = 0, n_core_en = 0, n_done = 0;

  knn_ctrl #(.DATA_W(DW), .LABEL_BITS(LB), .NBR_KNN(K), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .nbr_testp(nbr_testp), .nbr_datap(nbr_datap),
    .busy(busy), .done(done), .test_addr(test_addr), .test_rd(test_rd), .test_data(test_data),
    .data_addr(data_addr), .data_rd(data_rd), .data_in(data_in), .label_in(label_in),
    .core_en(core_en), .core_a(core_a), .core_b(core_b), .distance(distance),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_labels(res_labels)
  );

  always #5 clk = ~clk;

  // Squared Euclidean distance of two points packed {hi,lo} as 16-bit coordinates.
  function automatic logic [DW-1:0] pdist(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int dh, dl;
    dh = int'(a[31:16]) - int'(b[31:16]);
    dl = int'(a[15:0]) - int'(b[15:0]);
    return DW'(dh * dh + dl * dl);
  endfunction

  assign distance = pdist(core_a, core_b);

  // Point memories with one-cycle read latency.
  always @(posedge clk) begin
    if (test_rd) test_data <= test_mem[test_addr];
    if (data_rd) begin
      data_in  <= data_mem[data_addr];
      label_in <= label_mem[data_addr];
    end
  end

  always @(posedge clk) begin
    if (data_rd) n_data_rd++;
    if (test_rd) n_test_rd++;
    if (core_en) n_core_en++;
    if (done)    n_done++;
  end

  // Reference: repeatedly pick the smallest unused distance, lowest index winning ties.
  function automatic logic [K*LB-1:0] ref_labels(input int t, input int nd);
    logic [K*LB-1:0] r;
    bit used [256];
    int best;
    r = '0;
    for (int j = 0; j < 256; j++) used[j] = 1'b0;
    for (int k = 0; k < K; k++) begin
      best = -1;
      for (int j = 0; j < nd; j++) begin
        if (!used[j] && pdist(test_mem[t], data_mem[j]) != '1 &&
            (best < 0 || pdist(test_mem[t], data_mem[j]) < pdist(test_mem[t], data_mem[best])))
          best = j;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        r[k*LB +: LB] = label_mem[best];
      end
    end
    return r;
  endfunction

  task automatic fill_random(input int nt, input int nd);
    for (int i = 0; i < nt; i++)
      test_mem[i] = {16'($urandom_range(0, 60)), 16'($urandom_range(0, 60))};
    for (int j = 0; j < nd; j++) begin
      data_mem[j]  = {16'($urandom_range(0, 60)), 16'($urandom_range(0, 60))};
      label_mem[j] = LB'($urandom_range(1, 255));
    end
  endtask

  // Drives one run and checks every result, its timing and the strobe counts.
  task automatic run_job(input int nt, input int nd, input int hold, input bit poke,
                         input bit use_fixed, input logic [K*LB-1:0] fixed_lbl);
    int lat, exp_lat, rd0, en0, tr0;
    logic [K*LB-1:0] exp;
    @(negedge clk);
    nbr_testp = AW'(nt); nbr_datap = AW'(nd); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < nt; t++) begin
      rd0 = n_data_rd; en0 = n_core_en; tr0 = n_test_rd;
      exp = use_fixed ? fixed_lbl : ref_labels(t, nd);
      exp_lat = (nd == 0) ? 2 : nd + 3;
      checks++;
      if (test_rd !== 1'b1 || test_addr !== AW'(t) || busy !== 1'b1) begin
        errors++;
        $display("FAIL load t=%0d: test_rd=%0b test_addr=%0d busy=%0b, required 1/%0d/1", t, test_rd, test_addr, busy, t);
      end
      lat = 1;
      while (res_valid !== 1'b1 && lat < 2000) begin
        @(negedge clk);
        lat++;
        start = (poke && t == 0 && lat == 3);
        nbr_datap = (poke && t == 0 && lat == 3) ? AW'(nd + 3) : AW'(nd);
      end
      start = 1'b0; nbr_datap = AW'(nd);
      checks++;
      if (res_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout t=%0d: res_valid never rose within %0d cycles", t, lat);
        return;
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL latency t=%0d: got %0d cycles, required %0d", t, lat, exp_lat);
      end
      checks++;
      if (res_labels !== exp || res_idx !== AW'(t)) begin
        errors++;
        $display("FAIL result t=%0d: labels=%h idx=%0d, required labels=%h idx=%0d", t, res_labels, res_idx, exp, t);
      end
      checks++;
      if (n_data_rd - rd0 != nd || n_core_en - en0 != nd || n_test_rd - tr0 != 1) begin
        errors++;
        $display("FAIL strobes t=%0d: data_rd=%0d core_en=%0d test_rd=%0d, required %0d/%0d/1",
                 t, n_data_rd - rd0, n_core_en - en0, n_test_rd - tr0, nd, nd);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_labels !== exp || data_rd !== 1'b0 || test_rd !== 1'b0) begin
          errors++;
          $display("FAIL hold t=%0d h=%0d: valid=%0b labels=%h data_rd=%0b test_rd=%0b, required 1/%h/0/0",
                   t, h, res_valid, res_labels, data_rd, test_rd, exp);
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (t == nt - 1) begin
        if (res_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL finish: valid=%0b done=%0b busy=%0b, required 0/1/0", res_valid, done, busy);
        end
      end else if (res_valid !== 1'b0 || done !== 1'b0 || test_rd !== 1'b1) begin
        errors++;
        $display("FAIL next t=%0d: valid=%0b done=%0b test_rd=%0b, required 0/0/1", t, res_valid, done, test_rd);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle: done=%0b busy=%0b, required 0/0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, test_rd, data_rd, core_en, res_valid} !== 6'b0 ||
        test_addr !== '0 || data_addr !== '0 || core_a !== '0 || core_b !== '0 ||
        res_idx !== '0 || res_labels !== '0) begin
      errors++;
      $display("FAIL reset: busy=%0b done=%0b trd=%0b drd=%0b en=%0b valid=%0b labels=%h a=%h b=%h, required all 0",
               busy, done, test_rd, data_rd, core_en, res_valid, res_labels, core_a, core_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    test_mem[0] = 32'h0;
    data_mem[0] = {16'd3, 16'd4}; data_mem[1] = {16'd1, 16'd0}; data_mem[2] = {16'd0, 16'd2};
    data_mem[3] = {16'd5, 16'd5}; data_mem[4] = {16'd2, 16'd2};
    for (int j = 0; j < 5; j++) label_mem[j] = LB'(10 + j);
    run_job(1, 5, 0, 1'b0, 1'b1, {8'd10, 8'd14, 8'd12, 8'd11});
  endtask

  task automatic test_short_lists;
    test_mem[0] = 32'h0;
    data_mem[0] = {16'd1, 16'd0}; label_mem[0] = 8'd7;
    data_mem[1] = {16'd0, 16'd1}; label_mem[1] = 8'd9;
    run_job(1, 2, 0, 1'b0, 1'b1, {8'd0, 8'd0, 8'd9, 8'd7});
    run_job(1, 0, 0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_backpressure;
    fill_random(2, 7);
    run_job(2, 7, 5, 1'b0, 1'b0, '0);
  endtask

  task automatic test_start_while_busy;
    fill_random(2, 6);
    run_job(2, 6, 1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_zero_testp;
    int tr0, rd0;
    tr0 = n_test_rd; rd0 = n_data_rd;
    @(negedge clk);
    nbr_testp = '0; nbr_datap = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_testp done: got %0b, required 1", done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || n_test_rd != tr0 || n_data_rd != rd0) begin
      errors++;
      $display("FAIL zero_testp after: done=%0b busy=%0b test_rd=%0d data_rd=%0d, required 0/0/0/0",
               done, busy, n_test_rd - tr0, n_data_rd - rd0);
    end
  endtask

  task automatic test_reset_mid_run;
    int d0;
    fill_random(1, 20);
    @(negedge clk);
    nbr_testp = 8'd1; nbr_datap = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (data_rd !== 1'b1) begin
      errors++;
      $display("FAIL midrun stream: data_rd=%0b, required 1", data_rd);
    end
    d0 = n_done;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, test_rd, data_rd, core_en, res_valid} !== 6'b0 ||
        data_addr !== '0 || core_a !== '0 || core_b !== '0 || res_labels !== '0) begin
      errors++;
      $display("FAIL midrun reset: busy=%0b drd=%0b en=%0b addr=%0d a=%h labels=%h, required all 0",
               busy, data_rd, core_en, data_addr, core_a, res_labels);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun no_done: done pulses=%0d busy=%0b, required 0/0", n_done - d0, busy);
    end
    fill_random(2, 9);
    run_job(2, 9, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random;
    int nt, nd;
    for (int r = 0; r < 6; r++) begin
      nt = $urandom_range(1, 3);
      nd = $urandom_range(1, 14);
      fill_random(nt, nd);
      run_job(nt, nd, $urandom_range(0, 2), 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    nbr_testp = '0; nbr_datap = '0;
    test_reset();
    test_directed();
    test_short_lists();
    test_backpressure();
    test_start_while_busy();
    test_zero_testp();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
